block_fetcher: RTL
==================

Name: block_fetcher

Overview:
- Upstream stage of color_mapper: converts the current pixel position (DrawX, DrawY) plus a horizontal level scroll into the 3-bit blockID of the tile under that pixel.
- Playfield is 400x400 px at X 120..519, Y 40..439, built from 40x40 tiles (10 rows; 11 tile slots per line when scrolled).
- Runs on the pixel clock, one pixel per cycle.
- During each horizontal blank, prefetches the next line's tile row from the level map RAM into an 11-entry line buffer.
- Serves blockID from that buffer with zero latency.

Parameters:
- LEVEL_COLS, 64, level width in tiles (tile columns in map RAM).
- LEVEL_ROWS, 10, level height in tiles.
- MAP_LAT, 1, map RAM read latency in cycles (fixed, no stall).
- H_LOAD_START, 640, DrawX value that starts the line-buffer load.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous active-low reset.
- DrawX  in  10  current pixel column (0..799).
- DrawY  in  10  current pixel row (0..524).
- scroll_x  in  12  requested level scroll in pixels.
- map_rd  out  1  map RAM read strobe.
- map_addr  out  10  map RAM address = row*LEVEL_COLS + col.
- map_data  in  3  tile ID returned MAP_LAT cycles after map_rd.
- blockID  out  3  tile ID for the current pixel, to color_mapper.
- load_busy  out  1  high while a line-buffer load or scroll divide is in progress.

Behaviour:
- Reset (Reset==0 at a Clk edge) gives these values:
  - state IDLE.
  - Line buffer all 0.
  - coarse_col=0, fine_x=0, scroll latch 0.
  - map_rd=0, map_addr=0, load_busy=0, blockID=0.
- A reset mid-load or mid-divide aborts the operation, and the buffer clears to 0.
- Scroll latch:
  - At the edge where DrawY==480 && DrawX==0, latch scroll_x.
  - The latched value clamps to LEVEL_COLS*40-400 (2160) if larger.
  - Scroll changes take effect only at this point: no tearing within a frame.
- DIV state:
  - Entered from the latch.
  - Repeatedly subtracts 40, one subtraction per cycle, producing coarse_col = scroll/40 and fine_x = scroll%40.
  - Finishes within 55 cycles; completes before line 0.
  - load_busy is high throughout.
  - A latch event during DIV is impossible by timing and need not be handled.
- LOAD state:
  - Entered at DrawX==H_LOAD_START when next line L=(DrawY+1) mod 525 is within 40..439.
  - Tile row r=(L-40)/40.
  - Issues 11 consecutive reads, one per cycle, for slots i=0..10 with col=coarse_col+i.
  - map_rd=1 and map_addr valid on those cycles.
- DRAIN state:
  - Waits MAP_LAT cycles.
  - Each returned map_data is written to buffer slot i, in issue order.
  - Then returns to IDLE and load_busy falls.
  - Total time is 11+MAP_LAT cycles, well inside hblank.
- Column beyond level: if col>=LEVEL_COLS, issue no read (map_rd=0 for that cycle) and write slot i with 0 (air).
- Lines outside 40..439: no load; the buffer holds its contents.
- Output path:
  - Slot index s and sub-pixel counter are kept by registered counters.
  - s is reloaded so that in the cycle where DrawX==120, s==0 and sub==fine_x.
  - Each cycle sub increments; on 39 it wraps to 0 and s increments.
  - While DrawX in 120..519 and DrawY in 40..439: blockID = buffer[s], combinational from registers, same cycle as DrawX.
  - Otherwise blockID = 0.
- Arithmetic:
  - Row times LEVEL_COLS uses a shift when LEVEL_COLS is a power of two; a general multiply otherwise.
  - map_addr truncates to 10 bits.

Optional Feature:
- MAP_WRAP_EN defined:
  - Column index wraps modulo LEVEL_COLS instead of returning air.
  - The scroll clamp is replaced by scroll_x mod (LEVEL_COLS*40).
- Undefined: out-of-range columns yield 0 and scroll clamps to 2160.

Test Plan:
- Reset low for 3 cycles during LOAD -> map_rd=0, load_busy=0, blockID=0 on the cycle after release; buffer reads all 0.
- scroll_x=0, map row 0 = col index mod 8, DrawY=40 line, DrawX=120,159,160,519 -> blockID 0,0,1,1 (slot 9 -> 1).
- scroll_x=85 (coarse 2, fine 5), line 40 -> at DrawX=120 blockID=map[0][2], DrawX=155 -> map[0][3]; DIV finishes with load_busy low within 55 cycles.
- scroll_x=4000 -> latched 2160, coarse 54, fine 0; DrawX=519 gives map[r][63]; no read addresses >= row*64+64.
- MAP_WRAP_EN, scroll_x=2540 -> coarse 63, fine 20; slot 1 reads col 0; without the macro, scroll clamps to 2160.
- scroll_x changed mid-frame at DrawY=200 -> blockID unchanged until after DrawY=480 latch; line 40 of the next frame uses the new scroll.

Source files
------------

// File: rtl/block_fetcher.sv
// block_fetcher: turns the current pixel position plus a per-frame level
// scroll into the 3-bit tile ID under that pixel. During each horizontal
// blank it prefetches the next line's 11-tile row from the level map RAM
// into a line buffer, then serves blockID from that buffer with zero latency.
// Build option: define MAP_WRAP_EN to make the level wrap horizontally
// (column and scroll taken modulo the level width) instead of reading air
// past the right edge with the scroll clamped to the last full screen.
module block_fetcher #(
    parameter int LEVEL_COLS   = 64,
    parameter int LEVEL_ROWS   = 10,
    parameter int MAP_LAT      = 1,
    parameter int H_LOAD_START = 640
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [11:0] scroll_x,
    output logic        map_rd,
    output logic [9:0]  map_addr,
    input  logic [2:0]  map_data,
    output logic [2:0]  blockID,
    output logic        load_busy
);

    localparam int LEVEL_PX   = LEVEL_COLS * 40;
    localparam int SCROLL_MAX = LEVEL_PX - 400;
    localparam int SLOTS      = 11;
    localparam bit COLS_POW2  = (LEVEL_COLS & (LEVEL_COLS - 1)) == 0;
    localparam int COL_SH     = $clog2(LEVEL_COLS);

    typedef enum logic [1:0] {IDLE, DIV, LOAD, DRAIN} state_t;

    state_t      state_q;
    logic [11:0] scroll_q;      // latched scroll, reduced in place to the remainder
    logic [7:0]  quot_q;
    logic [7:0]  coarse_q;
    logic [5:0]  fine_q;
    logic [3:0]  idx_q;
    logic [3:0]  row_q;
    logic [3:0]  drain_q;
    logic [2:0]  buf_q       [SLOTS];
    logic        pipe_vld_q  [MAP_LAT+1];
    logic [3:0]  pipe_slot_q [MAP_LAT+1];
    logic        pipe_air_q  [MAP_LAT+1];
    logic [3:0]  s_q, s_d;
    logic [5:0]  sub_q, sub_d;

    logic [9:0]  next_line;
    logic        latch_go, load_go, issue_en, iss_air;
    logic [3:0]  iss_idx, iss_row;
    logic [8:0]  col_raw, iss_col;
    logic [9:0]  iss_addr;

    // Scroll as seen by the frame: clamped to the last full screen, or wrapped.
    function automatic logic [11:0] scroll_limit(input logic [11:0] s);
`ifdef MAP_WRAP_EN
        return 12'(int'(s) % LEVEL_PX);
`else
        return (int'(s) > SCROLL_MAX) ? 12'(SCROLL_MAX) : s;
`endif
    endfunction

    // Tile row of a playfield line (40..439) without a divider.
    function automatic logic [3:0] tile_row(input logic [9:0] line);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 1; k < 10; k++)
            if (int'(line) >= 40 + 40 * k) r = 4'(k);
        return r;
    endfunction

    // row*LEVEL_COLS + col, truncated to the RAM address width.
    function automatic logic [9:0] tile_addr(input logic [3:0] row, input logic [8:0] col);
        logic [19:0] base;
        if (COLS_POW2) base = 20'(row) << COL_SH;
        else           base = 20'(row) * 20'(LEVEL_COLS);
        return 10'(base + 20'(col));
    endfunction

    // Trigger decode and the address/air decision for the slot being issued.
    always_comb begin
        next_line = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
        latch_go  = (DrawY == 10'd480) && (DrawX == 10'd0);
        load_go   = (state_q == IDLE) && (DrawX == 10'(H_LOAD_START)) &&
                    (next_line >= 10'd40) && (next_line <= 10'd439);
        iss_idx   = (state_q == LOAD) ? idx_q : 4'd0;
        iss_row   = (state_q == LOAD) ? row_q : tile_row(next_line);
        issue_en  = !latch_go && (load_go || (state_q == LOAD));
        col_raw   = 9'(coarse_q) + 9'(iss_idx);
`ifdef MAP_WRAP_EN
        iss_col   = (int'(col_raw) >= LEVEL_COLS) ? 9'(int'(col_raw) - LEVEL_COLS) : col_raw;
        iss_air   = int'(iss_row) >= LEVEL_ROWS;
`else
        iss_col   = col_raw;
        iss_air   = (int'(col_raw) >= LEVEL_COLS) || (int'(iss_row) >= LEVEL_ROWS);
`endif
        iss_addr  = tile_addr(iss_row, iss_col);
    end

    // Control FSM: scroll latch and divide, then per-line read issue and drain.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            scroll_q  <= 12'd0;
            quot_q    <= 8'd0;
            coarse_q  <= 8'd0;
            fine_q    <= 6'd0;
            idx_q     <= 4'd0;
            row_q     <= 4'd0;
            drain_q   <= 4'd0;
            map_rd    <= 1'b0;
            map_addr  <= 10'd0;
            load_busy <= 1'b0;
        end else begin
            map_rd <= 1'b0;
            if (latch_go) begin
                scroll_q  <= scroll_limit(scroll_x);
                quot_q    <= 8'd0;
                state_q   <= DIV;
                load_busy <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (load_go) begin
                            map_rd    <= !iss_air;
                            map_addr  <= iss_addr;
                            row_q     <= iss_row;
                            idx_q     <= 4'd1;
                            state_q   <= LOAD;
                            load_busy <= 1'b1;
                        end
                    end
                    DIV: begin
                        if (scroll_q >= 12'd40) begin
                            scroll_q <= scroll_q - 12'd40;
                            quot_q   <= quot_q + 8'd1;
                        end else begin
                            coarse_q  <= quot_q;
                            fine_q    <= scroll_q[5:0];
                            state_q   <= IDLE;
                            load_busy <= 1'b0;
                        end
                    end
                    LOAD: begin
                        map_rd   <= !iss_air;
                        map_addr <= iss_addr;
                        idx_q    <= idx_q + 4'd1;
                        if (idx_q == 4'(SLOTS - 1)) begin
                            state_q <= DRAIN;
                            drain_q <= 4'd0;
                        end
                    end
                    DRAIN: begin
                        if (drain_q == 4'(MAP_LAT)) begin
                            state_q   <= IDLE;
                            load_busy <= 1'b0;
                        end else begin
                            drain_q <= drain_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Slot tags ride alongside the RAM latency; returning data lands in the buffer.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i <= MAP_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_slot_q[i] <= 4'd0;
                pipe_air_q[i]  <= 1'b0;
            end
            for (int j = 0; j < SLOTS; j++) buf_q[j] <= 3'd0;
        end else begin
            pipe_vld_q[0]  <= issue_en;
            pipe_slot_q[0] <= iss_idx;
            pipe_air_q[0]  <= iss_air;
            for (int i = 1; i <= MAP_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_slot_q[i] <= pipe_slot_q[i-1];
                pipe_air_q[i]  <= pipe_air_q[i-1];
            end
            if (pipe_vld_q[MAP_LAT])
                buf_q[pipe_slot_q[MAP_LAT]] <= pipe_air_q[MAP_LAT] ? 3'd0 : map_data;
        end
    end

    // Slot/sub-pixel next state: primed one pixel before the playfield starts.
    always_comb begin
        s_d   = s_q;
        sub_d = sub_q + 6'd1;
        if (DrawX == 10'd119) begin
            s_d   = 4'd0;
            sub_d = fine_q;
        end else if (sub_q == 6'd39) begin
            sub_d = 6'd0;
            s_d   = (s_q == 4'd15) ? s_q : s_q + 4'd1;
        end
    end

    // Slot/sub-pixel counters.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s_q   <= 4'd0;
            sub_q <= 6'd0;
        end else begin
            s_q   <= s_d;
            sub_q <= sub_d;
        end
    end

    // Tile ID for the current pixel; air outside the playfield.
    always_comb begin
        blockID = 3'd0;
        if ((DrawX >= 10'd120) && (DrawX <= 10'd519) &&
            (DrawY >= 10'd40) && (DrawY <= 10'd439) && (s_q <= 4'(SLOTS - 1)))
            blockID = buf_q[s_q];
    end

endmodule
